// File: rtl/conv_post_pool_if.sv
// rtl/conv_post_pool_if.sv - pixel input and pooled-activation output signals of conv_post_pool
interface conv_post_pool_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 188,
    parameter int IMAGE_HEIGHT = 64
);
    localparam int PCW = $clog2(IMAGE_WIDTH / 2);
    localparam int PRW = $clog2(IMAGE_HEIGHT / 2);

    logic                         frame_start;
    logic signed [DATA_WIDTH-1:0] mac_output;
    logic                         done;
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [DATA_WIDTH-1:0] pool_out;
    logic                         pool_valid;
    logic [PCW-1:0]               pool_col;
    logic [PRW-1:0]               pool_row;
    logic                         frame_done;
    logic                         busy;
    logic                         drop_err;

    modport master (
        output frame_start, mac_output, done, bias,
        input  pool_out, pool_valid, pool_col, pool_row, frame_done, busy, drop_err
    );

    modport slave (
        input  frame_start, mac_output, done, bias,
        output pool_out, pool_valid, pool_col, pool_row, frame_done, busy, drop_err
    );
endinterface

// File: rtl/conv_post_pool.sv
// rtl/conv_post_pool.sv - bias + saturate + ReLU, then 2x2/stride-2 max-pool with a half-width line buffer
module conv_post_pool #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_SZ      = 14,
    parameter int IMAGE_WIDTH  = 188,
    parameter int IMAGE_HEIGHT = 64
) (
    input logic             clk,
    input logic             rst,
    conv_post_pool_if.slave bus
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int HW = IMAGE_WIDTH / 2;
    localparam int SW = DATA_WIDTH + 1;
    localparam logic signed [SW-1:0] SAT_POS  = SW'(((1 << (DATA_WIDTH - FRAC_SZ - 1)) - 1) << FRAC_SZ);
    localparam logic signed [SW-1:0] SAT_NEG  = -SAT_POS;
    localparam logic [CW-1:0]        COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic                     accept, drop, last_px, busy, frame_done_d;
    logic [CW-1:0]            col_cnt_q, col_cnt_d, pos_col_q, pos_col_d;
    logic [RW-1:0]            row_cnt_q, row_cnt_d, pos_row_q, pos_row_d;
    logic signed [SW-1:0]     sum, clamped;
    logic signed [DATA_WIDTH-1:0] act_q, act_d, hmax_q, hmax_d, pmax, lb_rd;
    logic                     act_v_q, act_v_d, en2, lb_we;
    logic [CW-2:0]            lb_addr;
    logic signed [DATA_WIDTH-1:0] linebuf_q [HW];
    logic signed [DATA_WIDTH-1:0] pool_out_q, pool_out_d;
    logic                     pool_valid_q, pool_valid_d, frame_done_q, drop_err_q, drop_err_d;
    logic [CW-2:0]            pool_col_q, pool_col_d;
    logic [RW-2:0]            pool_row_q, pool_row_d;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.frame_start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (last_px) state_d = FLUSH;
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A pixel arriving with frame_start belongs to neither frame and is silently discarded.
    always_comb begin
        accept       = bus.done && (state_q == RUN) && !bus.frame_start;
        drop         = bus.done && (state_q != RUN) && !bus.frame_start;
        busy         = (state_q != IDLE);
        frame_done_d = (state_q == FLUSH) && !bus.frame_start;
    end

    always_comb begin
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        last_px    = accept && (col_cnt_q == COL_LAST) && (row_cnt_q == ROW_LAST);
        drop_err_d = bus.frame_start ? 1'b0 : (drop_err_q | drop);
        if (bus.frame_start) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (accept) begin
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end
    end

    // Stage 1: widen by one bit so the sum cannot wrap, clamp, then ReLU.
    always_comb begin
        sum = $signed({bus.mac_output[DATA_WIDTH-1], bus.mac_output})
            + $signed({bus.bias[DATA_WIDTH-1], bus.bias});
        if (sum > SAT_POS)      clamped = SAT_POS;
        else if (sum < SAT_NEG) clamped = SAT_NEG;
        else                    clamped = sum;
        if (clamped[SW-1]) clamped = '0;
        act_v_d   = accept;
        act_d     = accept ? clamped[DATA_WIDTH-1:0] : act_q;
        pos_col_d = accept ? col_cnt_q : pos_col_q;
        pos_row_d = accept ? row_cnt_q : pos_row_q;
    end

    // Stage 2: a restart edge also suppresses the pixel already sitting in stage 1.
    always_comb begin
        en2          = act_v_q && !bus.frame_start;
        lb_addr      = pos_col_q[CW-1:1];
        lb_rd        = linebuf_q[lb_addr];
        pmax         = (act_q > hmax_q) ? act_q : hmax_q;
        hmax_d       = (en2 && !pos_col_q[0]) ? act_q : hmax_q;
        lb_we        = en2 && pos_col_q[0] && !pos_row_q[0];
        pool_valid_d = en2 && pos_col_q[0] && pos_row_q[0];
        pool_out_d   = pool_out_q;
        pool_col_d   = pool_col_q;
        pool_row_d   = pool_row_q;
        if (pool_valid_d) begin
            pool_out_d = (lb_rd > pmax) ? lb_rd : pmax;
            pool_col_d = pos_col_q[CW-1:1];
            pool_row_d = pos_row_q[RW-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            pos_col_q    <= '0;
            pos_row_q    <= '0;
            act_q        <= '0;
            act_v_q      <= 1'b0;
            hmax_q       <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
            pool_col_q   <= '0;
            pool_row_q   <= '0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            pos_col_q    <= pos_col_d;
            pos_row_q    <= pos_row_d;
            act_q        <= act_d;
            act_v_q      <= act_v_d;
            hmax_q       <= hmax_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            pool_col_q   <= pool_col_d;
            pool_row_q   <= pool_row_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) linebuf_q[lb_addr] <= pmax;
    end

    assign bus.pool_out   = pool_out_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_col   = pool_col_q;
    assign bus.pool_row   = pool_row_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy;
    assign bus.drop_err   = drop_err_q;
endmodule

// File: doc/conv_post_pool.md
# conv_post_pool

Downstream stage of `mac_array`: consumes one saturated convolution result per `done` pulse, in raster order for a single output channel. Per pixel it adds the channel bias, saturates, and applies ReLU. It then 2×2 max-pools with stride 2 using a half-width line buffer. Pooled activations are emitted with position tags for the next conv layer's window buffer.

## Interface
- `DATA_WIDTH`, 16, width of all fixed-point samples (signed, Q(DATA_WIDTH-FRAC_SZ).FRAC_SZ).
- `FRAC_SZ`, 14, fractional bits.
- `IMAGE_WIDTH`, 188, conv output columns per row; must be even.
- `IMAGE_HEIGHT`, 64, conv output rows per frame; must be even.
- `clk` in 1: the single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; arms or restarts a frame.
- `mac_output` in DATA_WIDTH: signed conv result from `mac_array`.
- `done` in 1: `mac_output` is valid this cycle (one pixel per pulse).
- `bias` in DATA_WIDTH: signed channel bias; sampled together with `done`.
- `pool_out` out DATA_WIDTH: pooled activation, always ≥ 0.
- `pool_valid` out 1: `pool_out`, `pool_col` and `pool_row` are valid for one cycle.
- `pool_col` out $clog2(IMAGE_WIDTH/2): pooled column index.
- `pool_row` out $clog2(IMAGE_HEIGHT/2): pooled row index.
- `frame_done` out 1: one-cycle pulse, coincident with the last `pool_valid` of the frame.
- `busy` out 1: high from `frame_start` until `frame_done`.
- `drop_err` out 1: sticky flag; a `done` pulse was ignored.

## Operation
- **Saturation limits:** SAT_POS = ((1<<(DATA_WIDTH-FRAC_SZ-1))-1)<<FRAC_SZ and SAT_NEG = -SAT_POS. With the defaults these are +16384 and −16384.
- **FSM states:** IDLE, RUN, FLUSH.
  - IDLE → RUN on `frame_start`.
  - RUN → FLUSH when the pixel at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) is accepted.
  - FLUSH → IDLE after one cycle, once the pipeline has drained.
  - `frame_start` in any state clears `col_cnt`, `row_cnt` and `drop_err`, kills the in-flight stage-1 valid bit, and enters RUN.
- **Stage 1 (bias/ReLU):** on `done` in RUN, compute `s = mac_output + bias` at DATA_WIDTH+1 bits.
  - Clamp `s` to [SAT_NEG, SAT_POS].
  - If the clamped value is < 0, force it to 0.
  - Register the result as `act` and set `act_v`.
- **Stage 2 (pool):** on `act_v`, the position is `(row_cnt, col_cnt)`.
  - Even column: `hmax <= act`.
  - Odd column: `pmax = max(hmax, act)`.
    - Even row: `linebuf[col_cnt>>1] <= pmax`.
    - Odd row: `pool_out <= max(linebuf[col_cnt>>1], pmax)`, `pool_valid <= 1`, `pool_col <= col_cnt>>1`, `pool_row <= row_cnt>>1`.
  - `col_cnt` wraps from IMAGE_WIDTH-1 to 0 and increments `row_cnt` on wrap.
  - Counters advance when a pixel is accepted into stage 1; stage 2 uses a copy of the position registered alongside `act`.
- **Line buffer:** IMAGE_WIDTH/2 × DATA_WIDTH register array, no reset needed. Every entry is written on an even row before it is read on the following odd row.
- **Dropped pulses:** `done` in IDLE or FLUSH is ignored and sets `drop_err`. `done` in the same cycle as `frame_start` is ignored and does not set `drop_err`.
- **No back-pressure:** `done` may be asserted on every cycle.

## Timing
- Reset values: `pool_out` = 0, `pool_valid` = 0, `pool_col` = 0, `pool_row` = 0, `frame_done` = 0, `busy` = 0, `drop_err` = 0; counters 0; state IDLE.
- Latency: a `done` sampled at edge N carrying an odd-row, odd-column pixel gives `pool_valid` high in the cycle after edge N+1, i.e. 2 cycles.
- `busy` rises the cycle after `frame_start` and falls together with the `frame_done` pulse.
- `frame_done` is raised on the FLUSH→IDLE transition, in the same cycle as the final `pool_valid`.
- Throughput: 1 input pixel per cycle; ≤ 1 pooled output per 2 cycles.
- Mid-frame `frame_start`: no `pool_valid` is produced from pre-restart data after the restart edge.
- Reset during RUN: all outputs return to their reset values on the next edge.

## Test plan
Bench parameters: IMAGE_WIDTH=4, IMAGE_HEIGHT=4.
- **Constant frame:** `bias`=0, all 16 `mac_output`=0x03D7 on back-to-back `done` → 4 outputs of 983 at (0,0), (0,1), (1,0), (1,1); `frame_done` with the 4th output.
- **Max-pool ordering:** `bias`=0, inputs 1..16 in raster order → `pool_out` = 6, 8, 14, 16 in that order.
- **Saturation/ReLU:** all inputs 15360 with `bias`=2048 → all outputs 16384. All inputs −1000 with `bias`=0 → all outputs 0. Input −32768 with `bias`=−32768 → output 0.
- **Gapped input:** `done` with 3 idle cycles between pixels → same results as the constant frame; each `pool_valid` 2 cycles after its completing `done`.
- **Restart:** `frame_start` after 6 pixels, then a full frame of 1..16 → exactly outputs 6, 8, 14, 16; `drop_err`=0.
- **Drop/reset:** `done` while in IDLE → `drop_err`=1, no `pool_valid`. Then `rst`=0 for one edge → all outputs 0, state IDLE.
